// File: rtl/kc705_eth_cmd_pkg.sv
// rtl/kc705_eth_cmd_pkg.sv - shared sizes, field offsets and state encoding for the RX command parser
package kc705_eth_cmd_pkg;

  localparam int REG_WIDTH       = 4;
  localparam int NUM_REG         = 6;
  localparam int CMD_LENGTH      = 4;
  localparam int PKT_ID_LENGTH   = 4;
  localparam int REG_MAP_OUT_LEN = REG_WIDTH*NUM_REG + CMD_LENGTH + PKT_ID_LENGTH;
  localparam int MAP_W           = 8*REG_MAP_OUT_LEN;
  localparam int IDX_W           = $clog2(REG_MAP_OUT_LEN);

  // MSB positions of each field; first received byte lands in the top byte
  localparam int CMD_MSB    = MAP_W - 1;
  localparam int PKT_ID_MSB = CMD_MSB - 8*CMD_LENGTH;
  localparam int REG_BASE   = PKT_ID_MSB - 8*PKT_ID_LENGTH;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } state_e;

  typedef logic [MAP_W-1:0] reg_map_t;

  function automatic logic [8*REG_WIDTH-1:0] reg_field(input reg_map_t map, input int idx);
    return map[REG_BASE - 8*REG_WIDTH*idx -: 8*REG_WIDTH];
  endfunction

endpackage

// File: rtl/kc705_ethernet_rx_cmd_parser_if.sv
// rtl/kc705_ethernet_rx_cmd_parser_if.sv - byte stream in, register-map word out, frame status
interface kc705_ethernet_rx_cmd_parser_if;
  import kc705_eth_cmd_pkg::*;

  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready;
  reg_map_t    reg_map_tdata;
  logic        reg_map_tvalid;
  logic        reg_map_tready;
  logic        frame_err;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  modport master (
    output rx_tdata, rx_tvalid, rx_tlast, reg_map_tready,
    input  rx_tready, reg_map_tdata, reg_map_tvalid, frame_err, frames_ok, frames_err
  );

  modport slave (
    input  rx_tdata, rx_tvalid, rx_tlast, reg_map_tready,
    output rx_tready, reg_map_tdata, reg_map_tvalid, frame_err, frames_ok, frames_err
  );

endinterface

// File: rtl/kc705_idle_watchdog.sv
// rtl/kc705_idle_watchdog.sv - idle-cycle counter that fires once after LIMIT consecutive idle cycles
module kc705_idle_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_run && !i_clear && (r_cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || !i_run || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kc705_ethernet_rx_cmd_parser.sv
// rtl/kc705_ethernet_rx_cmd_parser.sv - RX payload bytes to register-map word; RX_CMD_TIMEOUT_EN adds idle-gap abort
module kc705_ethernet_rx_cmd_parser
  import kc705_eth_cmd_pkg::*;
`ifdef RX_CMD_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 1024)
`endif
(
  input  logic                           axi_tclk,
  input  logic                           axi_treset,
  kc705_ethernet_rx_cmd_parser_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_MAP_OUT_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_byte_idx, w_idx_nxt;
  reg_map_t         r_asm, w_asm_nxt, r_map;
  logic             r_ready_en, r_tvalid, r_frame_err;
  logic [15:0]      r_frames_ok, r_frames_err;
  logic             w_rx_tready, w_accept, w_take, w_publish, w_discard, w_timeout;

  assign w_rx_tready = r_ready_en && (r_state != HOLD);
  assign w_accept    = bus.rx_tvalid && w_rx_tready;
  assign w_take      = r_tvalid && bus.reg_map_tready;

`ifdef RX_CMD_TIMEOUT_EN
  kc705_idle_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_idle_watchdog (
    .clk      (axi_tclk),
    .rst      (axi_treset),
    .i_clear  (w_accept),
    .i_run    (((r_state == COLLECT) && (r_byte_idx != '0)) || (r_state == DRAIN)),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_byte_idx;
    w_asm_nxt   = r_asm;
    w_publish   = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_asm_nxt = {r_asm[MAP_W-9:0], bus.rx_tdata};
          if (r_byte_idx == LAST_IDX) begin
            if (bus.rx_tlast) begin
              w_publish   = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else if (bus.rx_tlast) begin
            w_discard = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_byte_idx + 1'b1;
          end
        end else if (w_timeout) begin
          w_discard = 1'b1;
          w_idx_nxt = '0;
        end
      end
      DRAIN: begin
        // assembled map stays frozen in r_asm while trailing bytes are dropped
        if (w_accept && bus.rx_tlast) begin
          w_publish   = 1'b1;
          w_state_nxt = HOLD;
        end else if (w_timeout) begin
          w_discard   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = COLLECT;
        end
      end
      HOLD: begin
        if (w_take) begin
          w_idx_nxt   = '0;
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = COLLECT;
      end
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      r_state      <= COLLECT;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_map        <= '0;
      r_ready_en   <= 1'b0;
      r_tvalid     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frames_ok  <= '0;
      r_frames_err <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_idx_nxt;
      r_asm       <= w_asm_nxt;
      r_ready_en  <= 1'b1;
      r_frame_err <= w_discard;
      if (w_publish) begin
        r_map       <= w_asm_nxt;
        r_tvalid    <= 1'b1;
        r_frames_ok <= r_frames_ok + 16'd1;
      end else if (w_take) begin
        r_tvalid <= 1'b0;
      end
      if (w_discard) begin
        r_frames_err <= r_frames_err + 16'd1;
      end
    end
  end

  assign bus.rx_tready      = w_rx_tready;
  assign bus.reg_map_tdata  = r_map;
  assign bus.reg_map_tvalid = r_tvalid;
  assign bus.frame_err      = r_frame_err;
  assign bus.frames_ok      = r_frames_ok;
  assign bus.frames_err     = r_frames_err;

endmodule

// File: tb/tb_kc705_ethernet_rx_cmd_parser.sv
// tb/tb_kc705_ethernet_rx_cmd_parser.sv - frame-level reference model plus directed frames for the RX command parser
module tb_kc705_ethernet_rx_cmd_parser;
  import kc705_eth_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  kc705_ethernet_rx_cmd_parser_if bus();

  always #5 clk = ~clk;

`ifdef RX_CMD_TIMEOUT_EN
  localparam int TO = 16;
  kc705_ethernet_rx_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .axi_tclk   (clk),
    .axi_treset (rst),
    .bus        (bus)
  );
`else
  kc705_ethernet_rx_cmd_parser dut (
    .axi_tclk   (clk),
    .axi_treset (rst),
    .bus        (bus)
  );
`endif

  localparam logic [255:0] S1_MAP =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] S3_MAP =
    256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Frame-level model: a frame is the list of bytes accepted up to tlast.
  logic [7:0]   q[$];
  logic [255:0] m_map     = '0;
  bit           m_pending = 1'b0;
  bit           m_ready   = 1'b0;
  bit           m_pulse   = 1'b0;
  bit           m_acc     = 1'b0;
  logic [15:0]  m_ok      = '0;
  logic [15:0]  m_err     = '0;
  int           m_idle    = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_map = '0; m_pending = 1'b0; m_ready = 1'b0; m_pulse = 1'b0;
      m_ok = '0; m_err = '0; m_idle = 0;
    end else begin
      m_acc   = m_ready && !m_pending && bus.rx_tvalid;
      m_pulse = 1'b0;
      if (m_pending) begin
        if (bus.reg_map_tready) m_pending = 1'b0;
      end else if (m_acc) begin
        q.push_back(bus.rx_tdata);
        m_idle = 0;
        if (bus.rx_tlast) begin
          if (q.size() < REG_MAP_OUT_LEN) begin
            m_err++;
            m_pulse = 1'b1;
          end else begin
            m_map = '0;
            for (int i = 0; i < REG_MAP_OUT_LEN; i++) m_map = {m_map[247:0], q[i]};
            m_pending = 1'b1;
            m_ok++;
          end
          q.delete();
        end
      end
`ifdef RX_CMD_TIMEOUT_EN
      else if (q.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_err++;
          m_pulse = 1'b1;
          q.delete();
          m_idle = 0;
        end
      end
`endif
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rx_tready",  256'(bus.rx_tready),      256'(0));
      chk("rst_tvalid",     256'(bus.reg_map_tvalid), 256'(0));
      chk("rst_frame_err",  256'(bus.frame_err),      256'(0));
      chk("rst_frames_ok",  256'(bus.frames_ok),      256'(0));
      chk("rst_frames_err", 256'(bus.frames_err),     256'(0));
      chk("rst_tdata",      bus.reg_map_tdata,        256'(0));
    end else begin
      chk("rx_tready",  256'(bus.rx_tready),      256'(m_ready && !m_pending));
      chk("tvalid",     256'(bus.reg_map_tvalid), 256'(m_pending));
      chk("frame_err",  256'(bus.frame_err),      256'(m_pulse));
      chk("frames_ok",  256'(bus.frames_ok),      256'(m_ok));
      chk("frames_err", 256'(bus.frames_err),     256'(m_err));
      if (m_pending) chk("tdata", bus.reg_map_tdata, m_map);
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int budget = 200;
    bit ok = 1'b0;
    bus.rx_tdata  = d;
    bus.rx_tvalid = 1'b1;
    bus.rx_tlast  = last;
    while (!ok && budget > 0) begin
      @(negedge clk);
      ok = bus.rx_tready;
      sync();
      budget--;
    end
    if (!ok) chk("send_accept_timeout", 256'(ok), 256'(1));
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input bit with_last);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i), with_last && (i == n - 1));
  endtask

  task automatic take_map();
    bus.reg_map_tready = 1'b1;
    sync();
    bus.reg_map_tready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int pulse_at;
    bus.rx_tdata = '0; bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.reg_map_tready = 1'b0;
    repeat (3) sync();
    rst = 1'b0;
    @(negedge clk);
    chk("L_ready_in_release_cycle", 256'(bus.rx_tready), 256'(0));
    sync();
    @(negedge clk);
    chk("L_ready_after_release", 256'(bus.rx_tready), 256'(1));
    sync();

    // 32-byte frame 0x00..0x1F
    send_frame(32, 8'h00, 1'b1);
    @(negedge clk);
    chk("L_s1_tvalid",    256'(bus.reg_map_tvalid), 256'(1));
    chk("L_s1_map",       bus.reg_map_tdata, S1_MAP);
    chk("L_s1_cmd",       256'(bus.reg_map_tdata[CMD_MSB -: 32]), 256'(32'h00010203));
    chk("L_s1_pkt_id",    256'(bus.reg_map_tdata[PKT_ID_MSB -: 32]), 256'(32'h04050607));
    chk("L_s1_reg5",      256'(reg_field(bus.reg_map_tdata, 5)), 256'(32'h1c1d1e1f));
    chk("L_s1_frames_ok", 256'(bus.frames_ok), 256'(1));

    // consumer stalls 50 cycles
    repeat (50) sync();
    @(negedge clk);
    chk("L_s4_hold_ready", 256'(bus.rx_tready), 256'(0));
    chk("L_s4_hold_map",   bus.reg_map_tdata, S1_MAP);
    sync();
    take_map();
    @(negedge clk);
    chk("L_s4_ready_after_take",  256'(bus.rx_tready), 256'(1));
    chk("L_s4_tvalid_after_take", 256'(bus.reg_map_tvalid), 256'(0));
    sync();

    // 10-byte short frame then a good one
    send_frame(10, 8'h20, 1'b1);
    @(negedge clk);
    chk("L_s2_err_pulse",  256'(bus.frame_err), 256'(1));
    chk("L_s2_frames_err", 256'(bus.frames_err), 256'(1));
    chk("L_s2_no_tvalid",  256'(bus.reg_map_tvalid), 256'(0));
    sync();
    @(negedge clk);
    chk("L_s2_pulse_ends", 256'(bus.frame_err), 256'(0));
    sync();
    send_frame(32, 8'h40, 1'b1);
    @(negedge clk);
    chk("L_s2_next_cmd", 256'(bus.reg_map_tdata[CMD_MSB -: 32]), 256'(32'h40414243));
    chk("L_s2_next_ok",  256'(bus.frames_ok), 256'(2));
    sync();
    take_map();

    // 40-byte frame, tail dropped
    send_frame(40, 8'h80, 1'b1);
    @(negedge clk);
    chk("L_s3_tvalid", 256'(bus.reg_map_tvalid), 256'(1));
    chk("L_s3_map",    bus.reg_map_tdata, S3_MAP);
    chk("L_s3_ok",     256'(bus.frames_ok), 256'(3));
    sync();
    take_map();

    // reset in the middle of a frame
    send_frame(12, 8'h10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("L_s5_rst_ok",    256'(bus.frames_ok), 256'(0));
    chk("L_s5_rst_err",   256'(bus.frames_err), 256'(0));
    chk("L_s5_rst_ready", 256'(bus.rx_tready), 256'(0));
    sync();
    sync();
    rst = 1'b0;
    sync();
    send_frame(32, 8'h00, 1'b1);
    @(negedge clk);
    chk("L_s5_map", bus.reg_map_tdata, S1_MAP);
    chk("L_s5_ok",  256'(bus.frames_ok), 256'(1));
    chk("L_s5_err", 256'(bus.frames_err), 256'(0));
    sync();
    take_map();

`ifdef RX_CMD_TIMEOUT_EN
    // 5 bytes then a 20-cycle idle gap
    send_frame(5, 8'h55, 1'b0);
    pulse_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.frame_err && pulse_at == 0) pulse_at = k;
      sync();
    end
    chk("L_s6_pulse_cycle", 256'(pulse_at), 256'(TO + 1));
    chk("L_s6_frames_err",  256'(bus.frames_err), 256'(1));
`else
    pulse_at = 0;
`endif

    repeat (3) sync();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
